// File: rtl/mux5_scan_serializer.sv
// mux5_scan_serializer
// Upstream controller for a 5:1 select mux. A word accepted on the input
// handshake is driven onto the mux data inputs. The select is then stepped
// through the five legal codes, one code per accepted serial beat. The mux
// output is returned as a valid/ready/last serial stream, and every
// transferred bit is checked against the latched word.

module mux5_scan_serializer #(
  parameter bit          MSB_FIRST = 1'b0, // 0: select 0->4, 1: select 4->0
  parameter int unsigned NUM_IN    = 5     // mux inputs; select width fixed at 3
) (
  input  logic       clk,
  input  logic       rst_n,      // synchronous, active-low
  // upstream word handshake
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  // mux drive and return
  output logic [4:0] mux_i,
  output logic [2:0] mux_s,
  input  logic       mux_y,
  // serial output stream
  output logic       ser_valid,
  output logic       ser_data,
  output logic       ser_last,
  input  logic       ser_ready,
  // status
  output logic       busy,
  output logic       sel_err
);

  // Highest legal select code. Codes above it (5..7) are never produced.
  localparam logic [2:0] HI_IDX    = 3'(NUM_IN - 1);
  localparam logic [2:0] START_IDX = MSB_FIRST ? HI_IDX : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0   : HI_IDX;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0] r_state;
  logic [4:0] r_mux_i;
  logic [2:0] r_mux_s;
  logic       r_sel_err;

  logic       w_idle;
  logic       w_scan;
  logic       w_accept;
  logic       w_beat;
  logic       w_at_end;
  logic       w_exp_bit;
  logic [2:0] w_step_s;

  // Decode handshake and beat conditions from the registered state.
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_scan    = (r_state == ST_SCAN);
    w_at_end  = (r_mux_s == END_IDX);
    w_accept  = w_idle & in_valid;
    w_beat    = w_scan & ser_ready;
    // The select only ever indexes 0..4, so this bit-select stays in range.
    w_exp_bit = r_mux_i[r_mux_s];
    w_step_s  = MSB_FIRST ? (r_mux_s - 3'd1) : (r_mux_s + 3'd1);
  end

  // State and select: load the start code on accept, advance on each
  // non-final beat, return to the start code after the final beat. A stalled
  // beat holds the select, so no bit is dropped or repeated.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mux_s <= START_IDX;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SCAN;
            r_mux_s <= START_IDX;
          end
        end
        ST_SCAN: begin
          if (w_beat) begin
            if (w_at_end) begin
              r_state <= ST_IDLE;
              r_mux_s <= START_IDX;
            end else begin
              r_mux_s <= w_step_s;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mux_s <= START_IDX;
        end
      endcase
    end
  end

  // Word register: captured on accept, held through and after the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mux_i <= 5'b00000;
    end else if (w_accept) begin
      r_mux_i <= in_data;
    end
  end

  // Sticky mismatch flag: set on any transferred beat whose mux output
  // disagrees with the latched word bit; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_beat && (mux_y != w_exp_bit)) begin
      r_sel_err <= 1'b1;
    end
  end

  // Output decode: all status outputs derive from registered state.
  always_comb begin
    in_ready  = w_idle;
    busy      = w_scan;
    ser_valid = w_scan;
    ser_data  = mux_y;
    ser_last  = w_scan & w_at_end;
    mux_i     = r_mux_i;
    mux_s     = r_mux_s;
    sel_err   = r_sel_err;
  end

endmodule

// File: tb/tb_mux5_scan_serializer.sv
// Testbench for mux5_scan_serializer. Two instances run in lockstep on shared
// stimulus: index 0 scans LSB-first, index 1 scans MSB-first. Each has its own
// behavioural 5:1 mux model with an optional fault on select code 3.

`timescale 1ns/1ps

module tb_mux5_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = 5'd0;
  logic       ser_ready = 1'b1;

  logic       rdy [2];
  logic [4:0] mi  [2];
  logic [2:0] ms  [2];
  logic       my  [2];
  logic       sv  [2];
  logic       sd  [2];
  logic       sl  [2];
  logic       bz  [2];
  logic       se  [2];
  logic       inj [2];

  int errs   = 0;
  int checks = 0;
  logic exp_err [2];

  always #5 clk = ~clk;

  // Ideal 5:1 mux, optionally inverting the bit selected by code 3.
  function automatic logic mux_model(input logic [4:0] w, input logic [2:0] s,
                                     input logic f);
    if (s > 3'd4) return 1'b0;
    return w[s] ^ (f && (s == 3'd3));
  endfunction

  // Select code expected on beat n (0..4) for the given scan direction.
  function automatic logic [2:0] exp_sel(input int d, input int n);
    return (d == 1) ? 3'(4 - n) : 3'(n);
  endfunction

  assign my[0] = mux_model(mi[0], ms[0], inj[0]);
  assign my[1] = mux_model(mi[1], ms[1], inj[1]);

  mux5_scan_serializer #(.MSB_FIRST(1'b0), .NUM_IN(5)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .mux_i(mi[0]), .mux_s(ms[0]), .mux_y(my[0]),
    .ser_valid(sv[0]), .ser_data(sd[0]), .ser_last(sl[0]), .ser_ready(ser_ready),
    .busy(bz[0]), .sel_err(se[0])
  );

  mux5_scan_serializer #(.MSB_FIRST(1'b1), .NUM_IN(5)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .mux_i(mi[1]), .mux_s(ms[1]), .mux_y(my[1]),
    .ser_valid(sv[1]), .ser_data(sd[1]), .ser_last(sl[1]), .ser_ready(ser_ready),
    .busy(bz[1]), .sel_err(se[1])
  );

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdy[d], sv[d], sl[d], bz[d], se[d]} !== 5'b10000)
        $display("FAIL reset_flags dut%0d: got rdy/sv/sl/bz/se=%b required 10000", d,
                 {rdy[d], sv[d], sl[d], bz[d], se[d]});
      checks++;
      if (mi[d] !== 5'd0) begin
        errs++; $display("FAIL reset_mux_i dut%0d: got %b required 00000", d, mi[d]);
      end
      checks++;
      if (ms[d] !== exp_sel(d, 0)) begin
        errs++; $display("FAIL reset_mux_s dut%0d: got %0d required %0d", d, ms[d], exp_sel(d, 0));
      end
    end
    if ({rdy[0], sv[0], sl[0], bz[0], se[0]} !== 5'b10000) errs++;
    if ({rdy[1], sv[1], sl[1], bz[1], se[1]} !== 5'b10000) errs++;
  endtask

  // Send one word, then scan it. Stall either on a fixed beat for a number of
  // cycles or randomly. Every cycle is compared against the reference model.
  task automatic run_frame(input logic [4:0] word, input int stall_beat,
                           input int stall_len, input bit rnd);
    int beat;
    int cyc;
    int left;
    logic [2:0] sel;
    logic       eb;
    logic [4:0] got [2];
    logic [4:0] want;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = word; ser_ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        errs++; $display("FAIL accept_ready dut%0d: got %b required 1", d, rdy[d]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 5'($urandom);
    beat = 0; cyc = 0; left = stall_len;
    got[0] = 5'd0; got[1] = 5'd0;
    while (beat < 5 && cyc < 60) begin
      if (rnd) ser_ready = ($urandom_range(0, 2) != 0);
      else if (beat == stall_beat && left > 0) begin ser_ready = 1'b0; left--; end
      else ser_ready = 1'b1;
      in_valid = 1'($urandom_range(0, 1));  // must be ignored while scanning
      in_data  = 5'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        sel = exp_sel(d, beat);
        eb  = word[sel] ^ (inj[d] && sel == 3'd3);
        checks++;
        if ({sv[d], bz[d], rdy[d]} !== 3'b110) begin
          errs++; $display("FAIL scan_flags dut%0d beat%0d: got sv/bz/rdy=%b required 110", d, beat,
                           {sv[d], bz[d], rdy[d]});
        end
        checks++;
        if (ms[d] !== sel) begin
          errs++; $display("FAIL scan_sel dut%0d beat%0d: got %0d required %0d", d, beat, ms[d], sel);
        end
        checks++;
        if (sd[d] !== eb) begin
          errs++; $display("FAIL scan_data dut%0d beat%0d: got %b required %b", d, beat, sd[d], eb);
        end
        checks++;
        if (sl[d] !== (beat == 4)) begin
          errs++; $display("FAIL scan_last dut%0d beat%0d: got %b required %b", d, beat, sl[d], beat == 4);
        end
        checks++;
        if (mi[d] !== word) begin
          errs++; $display("FAIL scan_word dut%0d: got %b required %b", d, mi[d], word);
        end
        checks++;
        if (se[d] !== exp_err[d]) begin
          errs++; $display("FAIL scan_sel_err dut%0d beat%0d: got %b required %b", d, beat, se[d], exp_err[d]);
        end
        if (ser_ready) begin
          got[d][beat] = sd[d];
          if (inj[d] && sel == 3'd3) exp_err[d] = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (ser_ready) beat++;
      cyc++;
    end
    in_valid = 1'b0; ser_ready = 1'b1;
    checks++;
    if (beat != 5) begin
      errs++; $display("FAIL frame_timeout: got %0d beats required 5", beat);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      want = 5'd0;
      for (int n = 0; n < 5; n++) want[n] = word[exp_sel(d, n)] ^ (inj[d] && exp_sel(d, n) == 3'd3);
      checks++;
      if (got[d] !== want) begin
        errs++; $display("FAIL frame_stream dut%0d: got %b required %b", d, got[d], want);
      end
      checks++;
      if ({rdy[d], sv[d], sl[d], bz[d]} !== 4'b1000) begin
        errs++; $display("FAIL frame_end_flags dut%0d: got rdy/sv/sl/bz=%b required 1000", d,
                         {rdy[d], sv[d], sl[d], bz[d]});
      end
      checks++;
      if (ms[d] !== exp_sel(d, 0) || mi[d] !== word) begin
        errs++; $display("FAIL frame_end_regs dut%0d: got s=%0d i=%b required s=%0d i=%b", d,
                         ms[d], mi[d], exp_sel(d, 0), word);
      end
      checks++;
      if (se[d] !== exp_err[d]) begin
        errs++; $display("FAIL frame_end_sel_err dut%0d: got %b required %b", d, se[d], exp_err[d]);
      end
    end
  endtask

  task automatic test_basic();
    run_frame(5'b10101, -1, 0, 1'b0);
    run_frame(5'b11001, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(5'b11001, 2, 3, 1'b0);
    run_frame(5'b01110, 0, 2, 1'b0);
    run_frame(5'b10011, 4, 4, 1'b0);
  endtask

  task automatic test_sel_err();
    inj[0] = 1'b1; inj[1] = 1'b1;
    run_frame(5'b10110, -1, 0, 1'b0);
    inj[0] = 1'b0; inj[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (se[d] !== 1'b1) begin
        errs++; $display("FAIL sel_err_sticky dut%0d: got %b required 1", d, se[d]);
      end
    end
    run_frame(5'b00101, -1, 0, 1'b0);
    test_reset();
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 5'b01101; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (sv[d] !== 1'b1 || sl[d] !== 1'b0 || ms[d] !== exp_sel(d, n)) begin
          errs++; $display("FAIL midrst_pre dut%0d beat%0d: got sv=%b sl=%b s=%0d required 1 0 %0d",
                           d, n, sv[d], sl[d], ms[d], exp_sel(d, n));
        end
      end
      if (n < 2) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({sv[d], sl[d], bz[d], rdy[d]} !== 4'b0001) begin
        errs++; $display("FAIL midrst_flags dut%0d: got sv/sl/bz/rdy=%b required 0001", d,
                         {sv[d], sl[d], bz[d], rdy[d]});
      end
      checks++;
      if (ms[d] !== exp_sel(d, 0) || mi[d] !== 5'd0) begin
        errs++; $display("FAIL midrst_regs dut%0d: got s=%0d i=%b required s=%0d i=00000", d,
                         ms[d], mi[d], exp_sel(d, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int nacc;
    logic [4:0] w;
    t1 = -1; t2 = -1; nacc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 5'b11111; ser_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ms[d] > 3'd4) begin
          errs++; $display("FAIL b2b_sel_range dut%0d cyc%0d: got %0d required <=4", d, cyc, ms[d]);
        end
        if (nacc >= 1 && (cyc > t1 && cyc <= t1 + 5 || nacc == 2 && cyc > t2 && cyc <= t2 + 5)) begin
          w = (nacc == 2 && cyc > t2) ? 5'b00000 : 5'b11111;
          checks++;
          if (sv[d] !== 1'b1 || sd[d] !== w[0]) begin
            errs++; $display("FAIL b2b_data dut%0d cyc%0d: got sv=%b d=%b required 1 %b", d, cyc,
                             sv[d], sd[d], w[0]);
          end
        end
      end
      if (in_valid && rdy[0] === 1'b1) begin
        nacc++;
        if (nacc == 1) t1 = cyc; else t2 = cyc;
      end
      @(posedge clk); #1;
      if (nacc == 1) in_data = 5'b00000;
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (nacc != 2 || t2 - t1 != 6) begin
      errs++; $display("FAIL b2b_spacing: got accepts=%0d gap=%0d required 2 and 6", nacc, t2 - t1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      run_frame(5'($urandom), -1, 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    inj[0] = 1'b0; inj[1] = 1'b0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sel_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
